// File: rtl/gcd_pkg.sv
// Shared types and sizing constants for the GCD / fraction-reduction path.
package gcd_pkg;

   typedef enum logic [1:0] {IDLE, DIV_A, DIV_B, DONE} state_t;

   localparam int LENGTH_DEF = 8;

   // Step counter must hold LENGTH-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int CNT_W = cnt_w(LENGTH_DEF);

endpackage

// File: rtl/frac_reduce_serial_div.sv
// Restoring divider producing one quotient bit per clock, MSB first.
module serial_div
   import gcd_pkg::*;
#(
   parameter int LENGTH = LENGTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LENGTH-1:0] dividend,
   input  logic [LENGTH-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [LENGTH-1:0] quotient,
   output logic              rem_nz
);

   localparam int CW = cnt_w(LENGTH);

   logic [LENGTH-1:0] dvd, dsr, quo, quo_n, dvd_n;
   logic [LENGTH-1:0] rem, rem_n;
   logic [LENGTH:0]   shifted, diff;
   logic [CW-1:0]     cnt;
   logic              ge;

   // Results are exposed for the step happening on this edge, so the caller
   // can capture them and restart the divider on the same edge.
   always_comb begin
      shifted = {rem, dvd[LENGTH-1]};
      diff    = shifted - {1'b0, dsr};
      ge      = (shifted >= {1'b0, dsr});
      rem_n   = ge ? diff[LENGTH-1:0] : shifted[LENGTH-1:0];
      quo_n   = quo << 1;
      quo_n[0] = ge;
      dvd_n   = dvd << 1;
   end

   assign done     = busy && (cnt == '0);
   assign quotient = quo_n;
   assign rem_nz   = (rem_n != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(LENGTH - 1);
      end else if (busy) begin
         if (cnt == '0)
            busy <= 1'b0;
         else
            cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         dvd <= dividend;
         dsr <= divisor;
         rem <= '0;
         quo <= '0;
      end else if (busy) begin
         dvd <= dvd_n;
         rem <= rem_n;
         quo <= quo_n;
      end
   end

endmodule

// File: rtl/frac_reduce.sv
// Divides a number pair by its GCD using one shared serial divider, with
// valid/ready handshakes on both sides.
module frac_reduce
   import gcd_pkg::*;
#(
   parameter int LENGTH = LENGTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LENGTH-1:0] in_num1,
   input  logic [LENGTH-1:0] in_num2,
   input  logic [LENGTH-1:0] in_gcd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LENGTH-1:0] out_num1,
   output logic [LENGTH-1:0] out_num2,
   output logic              out_err
);

   state_t            state;
   logic [LENGTH-1:0] num2_r, gcd_r, q1_r;
   logic              nz1_r;

   logic              div_start, div_busy, div_done, div_nz, div_last;
   logic [LENGTH-1:0] div_dividend, div_divisor, div_quo;

   assign in_ready = (state == IDLE);
   assign div_last = div_busy & div_done;

   // The second division is launched on the same edge the first one finishes.
   always_comb begin
      div_start    = 1'b0;
      div_dividend = in_num1;
      div_divisor  = in_gcd;
      if (state == IDLE) begin
         div_start = in_valid && (in_gcd != '0);
      end else if (state == DIV_A) begin
         div_start    = div_last;
         div_dividend = num2_r;
         div_divisor  = gcd_r;
      end
   end

   serial_div #(.LENGTH(LENGTH)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo),
      .rem_nz   (div_nz)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_num1  <= '0;
         out_num2  <= '0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  num2_r <= in_num2;
                  gcd_r  <= in_gcd;
                  if (in_gcd == '0) begin
                     out_num1  <= in_num1;
                     out_num2  <= in_num2;
                     out_err   <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= DIV_A;
                  end
               end
            end
            DIV_A: begin
               if (div_last) begin
                  q1_r  <= div_quo;
                  nz1_r <= div_nz;
                  state <= DIV_B;
               end
            end
            DIV_B: begin
               if (div_last) begin
                  out_num1  <= q1_r;
                  out_num2  <= div_quo;
                  out_err   <= nz1_r | div_nz;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frac_reduce.sv
// Bench for frac_reduce: transaction-level reference model plus directed
// and randomized transactions with backpressure and mid-flight reset.
module tb_frac_reduce;

   localparam int L = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [L-1:0] in_num1 = '0, in_num2 = '0, in_gcd = '0;
   logic         in_ready, out_valid, out_err;
   logic [L-1:0] out_num1, out_num2;

   int checks = 0;
   int errors = 0;

   frac_reduce #(.LENGTH(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num1   (in_num1),
      .in_num2   (in_num2),
      .in_gcd    (in_gcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_num1  (out_num1),
      .out_num2  (out_num2),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gcd_of(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Reference model: phase 0 idle, 1 computing, 2 holding a result.
   int           m_phase = 0;
   int           m_left = 0;
   bit           m_live = 1'b0;
   logic         m_valid = 1'b0, m_err = 1'b0, p_err = 1'b0;
   logic [L-1:0] m_n1 = '0, m_n2 = '0, p_n1 = '0, p_n2 = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_valid = 1'b0;
         m_n1    = '0;
         m_n2    = '0;
         m_err   = 1'b0;
         m_live  = 1'b1;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               if (in_gcd == 0) begin
                  m_n1    = in_num1;
                  m_n2    = in_num2;
                  m_err   = 1'b1;
                  m_valid = 1'b1;
                  m_phase = 2;
               end else begin
                  p_n1    = in_num1 / in_gcd;
                  p_n2    = in_num2 / in_gcd;
                  p_err   = ((in_num1 % in_gcd) != 0) || ((in_num2 % in_gcd) != 0);
                  m_left  = 2 * L - 1;
                  m_phase = 1;
               end
            end
            1: if (m_left == 0) begin
               m_n1    = p_n1;
               m_n2    = p_n2;
               m_err   = p_err;
               m_valid = 1'b1;
               m_phase = 2;
            end else begin
               m_left--;
            end
            default: if (out_ready) begin
               m_valid = 1'b0;
               m_phase = 0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_valid);
         chk("out_num1", out_num1, m_n1);
         chk("out_num2", out_num2, m_n2);
         chk("out_err", out_err, m_err);
      end
   end

   task automatic txn(input logic [L-1:0] a, input logic [L-1:0] b, input logic [L-1:0] g,
                      input int hold, input bit lit,
                      input logic [L-1:0] e1, input logic [L-1:0] e2, input logic ee);
      int           lat;
      logic [L-1:0] s1, s2;
      logic         se;
      @(negedge clk);
      in_num1   = a;
      in_num2   = b;
      in_gcd    = g;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_num1  = L'($urandom);
      in_num2  = L'($urandom);
      in_gcd   = L'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         in_valid = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      chk("latency", lat, (g == 0) ? 0 : 2 * L);
      if (lit) begin
         chk("lit_num1", out_num1, e1);
         chk("lit_num2", out_num2, e2);
         chk("lit_err", out_err, ee);
      end
      s1 = out_num1;
      s2 = out_num2;
      se = out_err;
      repeat (hold) begin
         in_valid = 1'b1;
         in_num1  = L'($urandom);
         in_num2  = L'($urandom);
         in_gcd   = L'($urandom);
         @(posedge clk);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
         chk("hold_num1", out_num1, s1);
         chk("hold_num2", out_num2, s2);
         chk("hold_err", out_err, se);
      end
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("release_ready", in_ready, 1);
      chk("release_valid", out_valid, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, g, sel;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_num1", out_num1, 0);
      chk("rst_out_num2", out_num2, 0);
      chk("rst_out_err", out_err, 0);

      txn(8'd96, 8'd40, 8'd8, 0, 1, 8'd12, 8'd5, 1'b0);
      txn(8'd0, 8'd0, 8'd0, 0, 1, 8'd0, 8'd0, 1'b1);
      txn(8'd255, 8'd85, 8'd85, 0, 1, 8'd3, 8'd1, 1'b0);
      txn(8'd10, 8'd7, 8'd3, 5, 1, 8'd3, 8'd2, 1'b1);
      txn(8'd200, 8'd150, 8'd50, 0, 1, 8'd4, 8'd3, 1'b0);
      txn(8'd255, 8'd1, 8'd1, 2, 1, 8'd255, 8'd1, 1'b0);
      txn(8'd13, 8'd26, 8'd0, 1, 1, 8'd13, 8'd26, 1'b1);

      // Reset landing in the middle of the second division.
      @(negedge clk);
      in_num1  = 8'd96;
      in_num2  = 8'd40;
      in_gcd   = 8'd8;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_num1", out_num1, 0);
      chk("midrst_out_num2", out_num2, 0);
      chk("midrst_out_err", out_err, 0);
      txn(8'd96, 8'd40, 8'd8, 0, 1, 8'd12, 8'd5, 1'b0);

      for (int i = 0; i < 150; i++) begin
         a   = $urandom_range(0, 255);
         b   = $urandom_range(0, 255);
         sel = $urandom_range(0, 9);
         if (sel < 7)      g = gcd_of(a, b);
         else if (sel < 9) g = $urandom_range(1, 255);
         else              g = 0;
         txn(L'(a), L'(b), L'(g), $urandom_range(0, 3), 0, '0, '0, 1'b0);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
